// File: rtl/upsp_pixel_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : upsp_pixel_serializer_if
// Brief    : Beat-in / pixel-stream-out handshake bundle for the serializer.
// Revision : 1.0  initial release
// ============================================================================
interface upsp_pixel_serializer_if #(
  parameter int BUFFER_WIDTH = 24
);
  logic [4*BUFFER_WIDTH-1:0] upsp_ac_wdata;
  logic                      upsp_ac_wvalid;
  logic                      ac_upsp_wready;
  logic [BUFFER_WIDTH-1:0]   m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic                      m_axis_tlast;
  logic                      m_axis_tuser;

  modport slave (
    input  upsp_ac_wdata, upsp_ac_wvalid, m_axis_tready,
    output ac_upsp_wready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport master (
    output upsp_ac_wdata, upsp_ac_wvalid, m_axis_tready,
    input  ac_upsp_wready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface
`default_nettype wire

// File: rtl/upsp_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : upsp_pixel_serializer
// Brief    : 2-deep FIFO of 4-pixel beats, serialized to 1 pixel/cycle with
//            tuser (frame start) and tlast (end of line). Optional frame
//            counter enabled by defining UPSP_SER_FRAME_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module upsp_pixel_serializer #(
  parameter int BUFFER_WIDTH = 24,
  parameter int DST_W        = 3840,
  parameter int DST_H        = 2160
) (
  input  logic                          clk,
  input  logic                          rst_n,
  upsp_pixel_serializer_if.slave        bus
`ifdef UPSP_SER_FRAME_CNT_EN
  ,
  output logic [15:0]                   frame_cnt
`endif
);

  localparam int COL_W = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam int ROW_W = (DST_H > 1) ? $clog2(DST_H) : 1;
  localparam logic [COL_W-1:0] c_col_last = COL_W'(DST_W - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(DST_H - 1);

  logic [4*BUFFER_WIDTH-1:0] mem_q [2];
  logic [4*BUFFER_WIDTH-1:0] mem_d [2];
  logic                      wr_ptr_q, wr_ptr_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic [1:0]                count_q, count_d;
  logic [1:0]                pix_idx_q, pix_idx_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;

  logic                      w_wready;
  logic                      w_tvalid;
  logic                      w_push;
  logic                      w_pop_pix;
  logic                      w_pop_beat;
  logic                      w_last_col;
  logic                      w_last_row;
  logic [4*BUFFER_WIDTH-1:0] w_head;

`ifdef UPSP_SER_FRAME_CNT_EN
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  assign frame_cnt = frame_cnt_q;
`endif

  // wready is gated by rst_n so it reads 0 throughout reset, never by tready.
  assign w_wready   = rst_n & (count_q != 2'd2);
  assign w_tvalid   = (count_q != 2'd0);
  assign w_push     = bus.upsp_ac_wvalid & w_wready;
  assign w_pop_pix  = w_tvalid & bus.m_axis_tready;
  assign w_pop_beat = w_pop_pix & (pix_idx_q == 2'd3);
  assign w_last_col = (col_q == c_col_last);
  assign w_last_row = (row_q == c_row_last);
  assign w_head     = mem_q[rd_ptr_q];

  assign bus.ac_upsp_wready = w_wready;
  assign bus.m_axis_tvalid  = w_tvalid;
  assign bus.m_axis_tdata   = w_tvalid ? w_head[pix_idx_q*BUFFER_WIDTH +: BUFFER_WIDTH]
                                       : '0;
  assign bus.m_axis_tlast   = w_last_col;
  assign bus.m_axis_tuser   = (row_q == '0) && (col_q == '0);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pix_idx_d = pix_idx_q;
    col_d     = col_q;
    row_d     = row_q;
`ifdef UPSP_SER_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif

    if (w_push) begin
      mem_d[wr_ptr_q] = bus.upsp_ac_wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_pop_beat) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({w_push, w_pop_beat})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (w_pop_pix) begin
      pix_idx_d = pix_idx_q + 2'd1;
      if (w_last_col) begin
        col_d = '0;
        if (w_last_row) begin
          row_d = '0;
`ifdef UPSP_SER_FRAME_CNT_EN
          frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      pix_idx_q <= 2'd0;
      col_q     <= '0;
      row_q     <= '0;
`ifdef UPSP_SER_FRAME_CNT_EN
      frame_cnt_q <= 16'd0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pix_idx_q <= pix_idx_d;
      col_q     <= col_d;
      row_q     <= row_d;
`ifdef UPSP_SER_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  // Storage needs no reset: tdata is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_upsp_pixel_serializer.sv
`default_nettype none
// Bench for upsp_pixel_serializer: directed and random traffic, scoreboard of
// expected pixels with line/frame markers derived from stream position.
module tb_upsp_pixel_serializer;
  localparam int BW        = 24;
  localparam int W         = 16;
  localparam int H         = 4;
  localparam int FRAME_PIX = W * H;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic          user;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upsp_pixel_serializer_if #(.BUFFER_WIDTH(BW)) bus ();
`ifdef UPSP_SER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  upsp_pixel_serializer #(.BUFFER_WIDTH(BW), .DST_W(W), .DST_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UPSP_SER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q [$];
  int unsigned pix_pushed = 0;
  int unsigned pix_out    = 0;
  bit          last_acc   = 1'b0;
  bit          last_hs    = 1'b0;
  int          n_acc      = 0;

  function automatic void chk(string name, logic [95:0] act, logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Model: every accepted beat contributes 4 pixels; markers follow from the
  // pixel's index in the stream since reset.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned col;
    if (!rst_n) begin
      exp_q.delete();
      pix_pushed = 0;
    end else if (bus.upsp_ac_wvalid && bus.ac_upsp_wready) begin
      for (int p = 0; p < 4; p++) begin
        col    = pix_pushed % W;
        e.data = bus.upsp_ac_wdata[p*BW +: BW];
        e.last = (col == W - 1);
        e.user = ((pix_pushed % FRAME_PIX) == 0);
        exp_q.push_back(e);
        pix_pushed++;
      end
    end
  end

  // Monitor: pops on each output handshake and checks stall stability.
  bit            prev_stall = 1'b0;
  logic [BW+1:0] prev_out;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      pix_out    = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {95'd0, bus.m_axis_tvalid}, 96'd1);
        chk("stall_hold", {70'd0, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser},
            {70'd0, prev_out});
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pixel", {72'd0, bus.m_axis_tdata}, 96'd0 - 96'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {72'd0, bus.m_axis_tdata}, {72'd0, e.data});
          chk("sb_tlast", {95'd0, bus.m_axis_tlast}, {95'd0, e.last});
          chk("sb_tuser", {95'd0, bus.m_axis_tuser}, {95'd0, e.user});
        end
        pix_out++;
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_out   = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
    end
  end

  // One clock of stimulus: drop an accepted beat, optionally offer a new one,
  // then sample at the falling edge what the next rising edge will do.
  task automatic cycle(input bit offer, input bit rdy, input bit use_fixed,
                       input logic [95:0] fixed);
    @(posedge clk);
    #1;
    if (last_acc) bus.upsp_ac_wvalid = 1'b0;
    bus.m_axis_tready = rdy;
    if (offer && !bus.upsp_ac_wvalid) begin
      bus.upsp_ac_wvalid = 1'b1;
      bus.upsp_ac_wdata  = use_fixed ? fixed : {$urandom, $urandom, $urandom};
    end
    @(negedge clk);
    last_acc = bus.upsp_ac_wvalid && bus.ac_upsp_wready && rst_n;
    last_hs  = bus.m_axis_tvalid && bus.m_axis_tready && rst_n;
    if (last_acc) n_acc++;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((bus.m_axis_tvalid || exp_q.size() != 0) && c < 200) begin
      cycle(1'b0, 1'b1, 1'b0, 96'd0);
      c++;
    end
    chk("drain_sb_empty", 96'(exp_q.size()), 96'd0);
    chk("drain_tvalid_low", {95'd0, bus.m_axis_tvalid}, 96'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] snap;
    int            acc0;
    int            sent;
    int            guard;
    logic [7:0]    b;

    bus.upsp_ac_wvalid = 1'b0;
    bus.upsp_ac_wdata  = '0;
    bus.m_axis_tready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wready", {95'd0, bus.ac_upsp_wready}, 96'd0);
    chk("rst_tvalid", {95'd0, bus.m_axis_tvalid}, 96'd0);
    chk("rst_tdata", {72'd0, bus.m_axis_tdata}, 96'd0);
    chk("rst_tlast", {95'd0, bus.m_axis_tlast}, 96'd0);
    chk("rst_tuser", {95'd0, bus.m_axis_tuser}, 96'd1);
`ifdef UPSP_SER_FRAME_CNT_EN
    chk("rst_frame_cnt", {80'd0, frame_cnt}, 96'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("wready_after_rst", {95'd0, bus.ac_upsp_wready}, 96'd1);

    // Single beat, first pixel one cycle after acceptance.
    cycle(1'b1, 1'b1, 1'b1, 96'h030303_020202_010101_000000);
    chk("t1_accept", {95'd0, last_acc}, 96'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 96'd0);
      b = 8'(i);
      chk("t1_valid", {95'd0, bus.m_axis_tvalid}, 96'd1);
      chk("t1_data", {72'd0, bus.m_axis_tdata}, {72'd0, b, b, b});
      chk("t1_tuser", {95'd0, bus.m_axis_tuser}, {95'd0, (i == 0)});
    end
    cycle(1'b0, 1'b1, 1'b0, 96'd0);
    chk("t1_done", {95'd0, bus.m_axis_tvalid}, 96'd0);

    // Backpressure: only two beats fit, then wready returns after 4 pixels.
    acc0 = n_acc;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 96'd0);
      if (c == 2) snap = bus.m_axis_tdata;
    end
    chk("bp_accepts", 96'(n_acc - acc0), 96'd2);
    chk("bp_wready_low", {95'd0, bus.ac_upsp_wready}, 96'd0);
    chk("bp_tdata_stable", {72'd0, bus.m_axis_tdata}, {72'd0, snap});
    for (int h = 0; h < 4; h++) begin
      cycle(1'b1, 1'b1, 1'b0, 96'd0);
      chk("bp_wready_hold", {95'd0, bus.ac_upsp_wready}, 96'd0);
      chk("bp_handshake", {95'd0, last_hs}, 96'd1);
    end
    cycle(1'b0, 1'b1, 1'b0, 96'd0);
    chk("bp_wready_back", {95'd0, bus.ac_upsp_wready}, 96'd1);
    drain();

    // Random traffic over three frames' worth of beats.
    sent  = 0;
    guard = 0;
    while (sent < 3 * FRAME_PIX / 4 && guard < 5000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 96'd0);
      if (last_acc) sent++;
      guard++;
    end
    chk("rand_all_sent", 96'(sent), 96'(3 * FRAME_PIX / 4));
    drain();
    chk("rand_pix_count", 96'(pix_out), 96'(pix_pushed));
`ifdef UPSP_SER_FRAME_CNT_EN
    chk("frame_cnt", {80'd0, frame_cnt}, 96'(pix_out / FRAME_PIX));
`endif

    // Mid-line reset with col = 5 and the FIFO full.
    while ((pix_out % W) != 0) cycle(1'b0, 1'b1, 1'b0, 96'd0);
    cycle(1'b1, 1'b0, 1'b0, 96'd0);
    cycle(1'b1, 1'b0, 1'b0, 96'd0);
    for (int h = 0; h < 5; h++) cycle(1'b0, 1'b1, 1'b0, 96'd0);
    cycle(1'b1, 1'b0, 1'b0, 96'd0);
    cycle(1'b0, 1'b0, 1'b0, 96'd0);
    chk("mid_full", {95'd0, bus.ac_upsp_wready}, 96'd0);
    chk("mid_col5", 96'(pix_out % W), 96'd5);
    @(posedge clk);
    #1;
    rst_n              = 1'b0;
    bus.upsp_ac_wvalid = 1'b0;
    last_acc           = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_tvalid", {95'd0, bus.m_axis_tvalid}, 96'd0);
    chk("mid_rst_wready", {95'd0, bus.ac_upsp_wready}, 96'd1);
    cycle(1'b1, 1'b1, 1'b1, 96'h0c0c0c_0b0b0b_0a0a0a_abcdef);
    cycle(1'b0, 1'b1, 1'b0, 96'd0);
    chk("mid_first_data", {72'd0, bus.m_axis_tdata}, 96'habcdef);
    chk("mid_first_tuser", {95'd0, bus.m_axis_tuser}, 96'd1);
    drain();
`ifdef UPSP_SER_FRAME_CNT_EN
    chk("mid_frame_cnt", {80'd0, frame_cnt}, 96'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
